// File: rtl/volatility_stats.sv
// volatility_stats: per-stock rolling window statistics (count, sum, sum of
// squares and the division-free variance numerator count*sumsq - sum^2).
// Samples live in a circular memory partitioned per stock; the sample being
// overwritten is the one evicted from the window.
// Optional build macro: VOLATILITY_CLEAR_EN adds i_clear / i_clear_id.
module volatility_stats #(
    parameter  int unsigned NUM_STOCKS  = 4,
    parameter  int unsigned BUFFER_SIZE = 20,
    parameter  int unsigned DATA_WIDTH  = 32,
    localparam int unsigned AW    = $clog2(NUM_STOCKS * BUFFER_SIZE),
    localparam int unsigned SW    = $clog2(NUM_STOCKS),
    localparam int unsigned CW    = $clog2(BUFFER_SIZE + 1),
    localparam int unsigned SUM_W = DATA_WIDTH + CW,
    localparam int unsigned SQ_W  = 2 * DATA_WIDTH + CW,
    localparam int unsigned VAR_W = 2 * SUM_W
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_addr_valid,
    input  logic [AW-1:0]         i_write_address,
    input  logic [SW-1:0]         i_stock_id,
    input  logic [DATA_WIDTH-1:0] i_price,
`ifdef VOLATILITY_CLEAR_EN
    input  logic                  i_clear,
    input  logic [SW-1:0]         i_clear_id,
`endif
    output logic                  o_ready,
    output logic                  o_drop,
    output logic                  o_addr_err,
    output logic                  o_stat_valid,
    output logic [SW-1:0]         o_stock_id,
    output logic [CW-1:0]         o_count,
    output logic [SUM_W-1:0]      o_sum,
    output logic [SQ_W-1:0]       o_sumsq,
    output logic [VAR_W-1:0]      o_var_num
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_UPDATE,
        S_CALC
    } state_t;

    state_t                state;
    logic [AW-1:0]         addr_q;
    logic [SW-1:0]         stk_q;
    logic [DATA_WIDTH-1:0] price_q;
    logic [DATA_WIDTH-1:0] old_mem;

    logic [DATA_WIDTH-1:0] mem [NUM_STOCKS * BUFFER_SIZE];

    logic [CW-1:0]    count_r [NUM_STOCKS];
    logic [SUM_W-1:0] sum_r   [NUM_STOCKS];
    logic [SQ_W-1:0]  sumsq_r [NUM_STOCKS];

    logic             clear_hit;
    logic [SW-1:0]    clear_id;

`ifdef VOLATILITY_CLEAR_EN
    assign clear_hit = i_clear;
    assign clear_id  = i_clear_id;
`else
    assign clear_hit = 1'b0;
    assign clear_id  = '0;
`endif

    // Partition check: the slot must lie inside the stock's own window region
    int unsigned part_lo;
    logic        addr_ok;
    always_comb begin
        part_lo = 32'(i_stock_id) * BUFFER_SIZE;
        addr_ok = (32'(i_stock_id) < NUM_STOCKS) &&
                  (32'(i_write_address) >= part_lo) &&
                  (32'(i_write_address) < part_lo + BUFFER_SIZE);
    end

    // Window update: before the window is full the evicted slot holds no sample
    logic                  full;
    logic [DATA_WIDTH-1:0] old_val;
    logic [CW-1:0]         new_count;
    logic [SUM_W-1:0]      new_sum;
    logic [SQ_W-1:0]       new_sq;
    logic [SQ_W-1:0]       px_w;
    logic [SQ_W-1:0]       old_w;
    always_comb begin
        full      = (count_r[stk_q] == CW'(BUFFER_SIZE));
        old_val   = full ? old_mem : '0;
        new_count = full ? count_r[stk_q] : count_r[stk_q] + 1'b1;
        new_sum   = sum_r[stk_q] + SUM_W'(price_q) - SUM_W'(old_val);
        px_w      = SQ_W'(price_q);
        old_w     = SQ_W'(old_val);
        new_sq    = sumsq_r[stk_q] + px_w * px_w - old_w * old_w;
    end

    // Variance numerator from the already-updated per-stock registers
    logic [VAR_W-1:0] cnt_v;
    logic [VAR_W-1:0] sum_v;
    logic [VAR_W-1:0] sq_v;
    logic [VAR_W-1:0] var_c;
    always_comb begin
        cnt_v = VAR_W'(count_r[stk_q]);
        sum_v = VAR_W'(sum_r[stk_q]);
        sq_v  = VAR_W'(sumsq_r[stk_q]);
        var_c = cnt_v * sq_v - sum_v * sum_v;
    end

    // Sample memory: unreset storage, read in READ and written in UPDATE
    always_ff @(posedge i_clk) begin
        if (state == S_READ) begin
            old_mem <= mem[addr_q];
        end
        if (state == S_UPDATE) begin
            mem[addr_q] <= price_q;
        end
    end

    // Control FSM with registered outputs and per-stock statistics
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state        <= S_IDLE;
            addr_q       <= '0;
            stk_q        <= '0;
            price_q      <= '0;
            o_ready      <= 1'b1;
            o_drop       <= 1'b0;
            o_addr_err   <= 1'b0;
            o_stat_valid <= 1'b0;
            o_stock_id   <= '0;
            o_count      <= '0;
            o_sum        <= '0;
            o_sumsq      <= '0;
            o_var_num    <= '0;
            for (int unsigned i = 0; i < NUM_STOCKS; i++) begin
                count_r[i] <= '0;
                sum_r[i]   <= '0;
                sumsq_r[i] <= '0;
            end
        end else begin
            o_drop       <= 1'b0;
            o_addr_err   <= 1'b0;
            o_stat_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (clear_hit) begin
                        count_r[clear_id] <= '0;
                        sum_r[clear_id]   <= '0;
                        sumsq_r[clear_id] <= '0;
                        o_drop            <= i_addr_valid;
                    end else if (i_addr_valid) begin
                        if (addr_ok) begin
                            addr_q  <= i_write_address;
                            stk_q   <= i_stock_id;
                            price_q <= i_price;
                            o_ready <= 1'b0;
                            state   <= S_READ;
                        end else begin
                            o_addr_err <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    o_drop <= i_addr_valid;
                    state  <= S_UPDATE;
                end
                S_UPDATE: begin
                    o_drop         <= i_addr_valid;
                    count_r[stk_q] <= new_count;
                    sum_r[stk_q]   <= new_sum;
                    sumsq_r[stk_q] <= new_sq;
                    state          <= S_CALC;
                end
                S_CALC: begin
                    o_drop       <= i_addr_valid;
                    o_stat_valid <= 1'b1;
                    o_stock_id   <= stk_q;
                    o_count      <= count_r[stk_q];
                    o_sum        <= sum_r[stk_q];
                    o_sumsq      <= sumsq_r[stk_q];
                    o_var_num    <= var_c;
                    o_ready      <= 1'b1;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_volatility_stats.sv
// tb_volatility_stats: table-driven vectors with a scoreboard queue for the
// statistics outputs, plus hand sequences for drop, address error, reset and
// (when VOLATILITY_CLEAR_EN is defined) clear behaviour. BUFFER_SIZE = 4.
module tb_volatility_stats;

    localparam int NS    = 4;
    localparam int BS    = 4;
    localparam int DW    = 32;
    localparam int AW    = $clog2(NS * BS);
    localparam int SW    = $clog2(NS);
    localparam int CW    = $clog2(BS + 1);
    localparam int SUM_W = DW + CW;
    localparam int SQ_W  = 2 * DW + CW;
    localparam int VAR_W = 2 * SUM_W;

    typedef struct packed {
        logic [SW-1:0]    stock;
        logic [AW-1:0]    addr;
        logic [DW-1:0]    price;
        logic [CW-1:0]    cnt;
        logic [SUM_W-1:0] sum;
        logic [SQ_W-1:0]  sq;
        logic [VAR_W-1:0] vn;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             addr_valid = 1'b0;
    logic [AW-1:0]    write_address = '0;
    logic [SW-1:0]    stock_id = '0;
    logic [DW-1:0]    price = '0;
`ifdef VOLATILITY_CLEAR_EN
    logic             clear = 1'b0;
    logic [SW-1:0]    clear_id = '0;
`endif
    logic             ready;
    logic             drop;
    logic             addr_err;
    logic             stat_valid;
    logic [SW-1:0]    o_stock;
    logic [CW-1:0]    count;
    logic [SUM_W-1:0] sum;
    logic [SQ_W-1:0]  sumsq;
    logic [VAR_W-1:0] var_num;

    int   checks = 0;
    int   errors = 0;
    vec_t sb[$];
    vec_t tbl[11];

    always #5 clk = ~clk;

    volatility_stats #(
        .NUM_STOCKS (NS),
        .BUFFER_SIZE(BS),
        .DATA_WIDTH (DW)
    ) dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_addr_valid   (addr_valid),
        .i_write_address(write_address),
        .i_stock_id     (stock_id),
        .i_price        (price),
`ifdef VOLATILITY_CLEAR_EN
        .i_clear        (clear),
        .i_clear_id     (clear_id),
`endif
        .o_ready        (ready),
        .o_drop         (drop),
        .o_addr_err     (addr_err),
        .o_stat_valid   (stat_valid),
        .o_stock_id     (o_stock),
        .o_count        (count),
        .o_sum          (sum),
        .o_sumsq        (sumsq),
        .o_var_num      (var_num)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Present one strobe across one rising edge; returns #1 after that edge
    task automatic strobe(input logic [SW-1:0] s, input logic [AW-1:0] a, input logic [DW-1:0] p);
        @(negedge clk);
        addr_valid    = 1'b1;
        stock_id      = s;
        write_address = a;
        price         = p;
        @(posedge clk);
        #1;
        addr_valid = 1'b0;
    endtask

    // Accepted sample: expected stats queued, latency and ready checked here
    task automatic sample(input vec_t v);
        sb.push_back(v);
        strobe(v.stock, v.addr, v.price);
        chk("ready_low_after_accept", ready, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("no_early_stat_valid", stat_valid, 1'b0);
        end
        @(posedge clk);
        #1;
        chk("stat_valid_at_t3", stat_valid, 1'b1);
        chk("ready_in_valid_cycle", ready, 1'b1);
    endtask

    // Scoreboard: every stat_valid must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n && stat_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_stat_valid: got 1 expected 0");
            end else begin
                vec_t e;
                e = sb.pop_front();
                chk("stock_id", o_stock, e.stock);
                chk("count", count, e.cnt);
                chk("sum", sum, e.sum);
                chk("sumsq", sumsq, e.sq);
                chk("var_num", var_num, e.vn);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // stock, addr, price, count, sum, sumsq, var_num
        tbl[0]  = '{2'd1, 4'd4, 32'd10, 3'd1, 35'd10,  67'd100,  70'd0};
        tbl[1]  = '{2'd1, 4'd5, 32'd20, 3'd2, 35'd30,  67'd500,  70'd100};
        tbl[2]  = '{2'd1, 4'd6, 32'd30, 3'd3, 35'd60,  67'd1400, 70'd600};
        tbl[3]  = '{2'd1, 4'd7, 32'd40, 3'd4, 35'd100, 67'd3000, 70'd2000};
        tbl[4]  = '{2'd1, 4'd4, 32'd50, 3'd4, 35'd140, 67'd5400, 70'd2000};
        tbl[5]  = '{2'd0, 4'd0, 32'd5,  3'd1, 35'd5,   67'd25,   70'd0};
        tbl[6]  = '{2'd0, 4'd1, 32'd5,  3'd2, 35'd10,  67'd50,   70'd0};
        tbl[7]  = '{2'd0, 4'd2, 32'd5,  3'd3, 35'd15,  67'd75,   70'd0};
        tbl[8]  = '{2'd0, 4'd3, 32'd5,  3'd4, 35'd20,  67'd100,  70'd0};
        tbl[9]  = '{2'd0, 4'd0, 32'd5,  3'd4, 35'd20,  67'd100,  70'd0};
        tbl[10] = '{2'd0, 4'd1, 32'd5,  3'd4, 35'd20,  67'd100,  70'd0};

        // Reset values
        #12;
        chk("rst_ready", ready, 1'b1);
        chk("rst_drop", drop, 1'b0);
        chk("rst_addr_err", addr_err, 1'b0);
        chk("rst_stat_valid", stat_valid, 1'b0);
        chk("rst_sum", sum, 0);
        chk("rst_var_num", var_num, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill/evict on stock 1 and constant input on stock 0, back to back
        for (int i = 0; i < 11; i++) begin
            sample(tbl[i]);
        end

        // Busy drop: second strobe one cycle after the accept
        sb.push_back('{2'd2, 4'd8, 32'd9, 3'd1, 35'd9, 67'd81, 70'd0});
        strobe(2'd2, 4'd8, 32'd9);
        chk("busy_ready_low", ready, 1'b0);
        strobe(2'd2, 4'd9, 32'd100);
        chk("busy_drop_pulse", drop, 1'b1);
        @(posedge clk);
        #1;
        chk("busy_drop_one_cycle", drop, 1'b0);
        chk("busy_no_early_valid", stat_valid, 1'b0);
        @(posedge clk);
        #1;
        chk("busy_stat_valid", stat_valid, 1'b1);
        chk("busy_ready_in_valid", ready, 1'b1);

        // Address errors: outside the stock's partition on either side
        strobe(2'd0, 4'd5, 32'd123);
        chk("aerr_pulse_hi", addr_err, 1'b1);
        chk("aerr_ready", ready, 1'b1);
        chk("aerr_no_drop", drop, 1'b0);
        @(posedge clk);
        #1;
        chk("aerr_one_cycle", addr_err, 1'b0);
        strobe(2'd1, 4'd3, 32'd77);
        chk("aerr_pulse_lo", addr_err, 1'b1);
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("aerr_no_stat_valid", stat_valid, 1'b0);
        end
        // stock 0 still holds four 5s: replacing one by 9
        sample('{2'd0, 4'd2, 32'd9, 3'd4, 35'd24, 67'd156, 70'd48});

`ifdef VOLATILITY_CLEAR_EN
        // Clear stock 1 in IDLE, then one sample restarts its window
        @(negedge clk);
        clear    = 1'b1;
        clear_id = 2'd1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        chk("clear_no_stat", stat_valid, 1'b0);
        sample('{2'd1, 4'd5, 32'd7, 3'd1, 35'd7, 67'd49, 70'd0});
        // Clear coincident with a strobe: the strobe is dropped
        @(negedge clk);
        clear         = 1'b1;
        clear_id      = 2'd2;
        addr_valid    = 1'b1;
        stock_id      = 2'd2;
        write_address = 4'd8;
        price         = 32'd3;
        @(posedge clk);
        #1;
        clear      = 1'b0;
        addr_valid = 1'b0;
        chk("clear_drop_pulse", drop, 1'b1);
        chk("clear_ready", ready, 1'b1);
        @(posedge clk);
        #1;
        chk("clear_drop_one_cycle", drop, 1'b0);
        chk("clear_strobe_no_stat", stat_valid, 1'b0);
        sample('{2'd2, 4'd9, 32'd4, 3'd1, 35'd4, 67'd16, 70'd0});
`endif

        // Reset during UPDATE: in-flight sample vanishes, statistics cleared
        sample('{2'd3, 4'd12, 32'd11, 3'd1, 35'd11, 67'd121, 70'd0});
        strobe(2'd3, 4'd13, 32'd77);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", ready, 1'b1);
        chk("midrst_stat_valid", stat_valid, 1'b0);
        chk("midrst_count", count, 0);
        chk("midrst_sum", sum, 0);
        chk("midrst_sumsq", sumsq, 0);
        chk("midrst_var_num", var_num, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("midrst_no_stat_valid", stat_valid, 1'b0);
        end
        sample('{2'd3, 4'd14, 32'd6, 3'd1, 35'd6, 67'd36, 70'd0});
        sample('{2'd1, 4'd6, 32'd3, 3'd1, 35'd3, 67'd9, 70'd0});

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
